// File: rtl/mem_pkg.sv
// Shared constants and types for the 8-word register memory and its request port.
package mem_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;
endpackage

// File: rtl/ram8_req_port_if.sv
// Valid/ready request and response channels between a requester and ram8_req_port.
interface ram8_req_port_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    word_t             req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    word_t             rsp_data;
    logic              rsp_we;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_we, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_we, rsp_err
    );
endinterface

// File: rtl/demux_1to8.sv
// Routes a single bit to one of eight outputs; with din tied high it is a one-hot decoder.
module demux_1to8 (
    input  logic       din,
    input  logic [2:0] sel,
    output logic [7:0] y
);
    always_comb begin
        y      = '0;
        y[sel] = din;
    end
endmodule

// File: rtl/mux_8to1.sv
// Eight-way word selector used on the read path.
module mux_8to1 #(
    parameter int W = 16
) (
    input  logic [2:0]   sel,
    input  logic [W-1:0] d [8],
    output logic [W-1:0] y
);
    assign y = d[sel];
endmodule

// File: rtl/ram8_req_port.sv
// 8 x 16-bit register memory behind a valid/ready request port with a registered,
// one-cycle-latency response that holds under backpressure.
module ram8_req_port
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    ram8_req_port_if.slave   bus,
    output logic [DEPTH-1:0] word_valid
);
    state_t           state_q, state_d;
    word_t            mem_q [DEPTH];
    word_t            mem_d [DEPTH];
    logic [DEPTH-1:0] word_valid_q, word_valid_d;
    word_t            rsp_data_q, rsp_data_d;
    logic             rsp_we_q, rsp_we_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept;
    logic [DEPTH-1:0] dec_onehot;
    logic [DEPTH-1:0] wr_en;
    word_t            rd_word;
    logic             rd_err;

    // A held response frees the port in the same cycle it is consumed.
    assign bus.req_ready = rst_n && (state_q == IDLE || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    demux_1to8 u_wr_dec (
        .din (1'b1),
        .sel (bus.req_addr),
        .y   (dec_onehot)
    );

    mux_8to1 #(.W(DATA_W)) u_rd_mux (
        .sel (bus.req_addr),
        .d   (mem_q),
        .y   (rd_word)
    );

    assign wr_en  = dec_onehot & {DEPTH{accept && bus.req_we}};
    assign rd_err = ~word_valid_q[bus.req_addr];

    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_we_d     = rsp_we_q;
        rsp_err_d    = rsp_err_q;
        word_valid_d = word_valid_q | wr_en;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = wr_en[i] ? bus.req_wdata : mem_q[i];
        end

        if (accept) begin
            state_d  = RESP;
            rsp_we_d = bus.req_we;
            if (bus.req_we) begin
                rsp_data_d = bus.req_wdata;
                rsp_err_d  = 1'b0;
            end else begin
                rsp_data_d = rd_err ? '0 : rd_word;
                rsp_err_d  = rd_err;
            end
        end else if (state_q == RESP && bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_valid_q <= '0;
            rsp_data_q   <= '0;
            rsp_we_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            word_valid_q <= word_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_we_q     <= rsp_we_d;
            rsp_err_q    <= rsp_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_err   = rsp_err_q;
    assign word_valid    = word_valid_q;
endmodule

// File: tb/tb_ram8_req_port.sv
// Directed-vector bench for ram8_req_port; inputs driven and outputs sampled on falling edges.
module tb_ram8_req_port;
    import mem_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [DEPTH-1:0] word_valid;
    int               n_checks;
    int               n_fail;

    ram8_req_port_if bus ();

    ram8_req_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .word_valid (word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [2:0] addr, input word_t wdata);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic we, input logic err, input word_t data);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
        check({tag, "_we"},    32'(bus.rsp_we),    32'(we));
        check({tag, "_err"},   32'(bus.rsp_err),   32'(err));
        check({tag, "_data"},  32'(bus.rsp_data),  32'(data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_rsp("rst", 1'b0, 1'b0, 1'b0, 16'h0000);
        check("rst_word_valid", 32'(word_valid), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Read of an unwritten word
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 3'd5, 16'h0000);
        check("rd5_pre_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);
        check_rsp("rd5", 1'b1, 1'b0, 1'b1, 16'h0000);
        check("rd5_word_valid", 32'(word_valid), 32'h00);
        @(negedge clk);
        check("rd5_drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Write then read back-to-back
        drive_req(1'b1, 1'b1, 3'd3, 16'hBEEF);
        @(negedge clk);
        check_rsp("wr3", 1'b1, 1'b1, 1'b0, 16'hBEEF);
        check("wr3_word_valid", 32'(word_valid), 32'h08);
        drive_req(1'b1, 1'b0, 3'd3, 16'h0000);
        @(negedge clk);
        check_rsp("rd3", 1'b1, 1'b0, 1'b0, 16'hBEEF);
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("rd3_drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Full-rate fill then full-rate readout
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, 1'b1, 3'(i), 16'(16'h1111 * (i + 1)));
            @(negedge clk);
            check_rsp($sformatf("fill%0d", i), 1'b1, 1'b1, 1'b0, 16'(16'h1111 * (i + 1)));
        end
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, 1'b0, 3'(i), 16'h0000);
            @(negedge clk);
            check_rsp($sformatf("dump%0d", i), 1'b1, 1'b0, 1'b0, 16'(16'h1111 * (i + 1)));
        end
        check("fill_word_valid", 32'(word_valid), 32'hFF);
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);

        // Backpressure on a pending read of addr 2, with addr 4 queued behind it
        drive_req(1'b1, 1'b0, 3'd2, 16'h0000);
        @(negedge clk);
        check_rsp("bp_rd2", 1'b1, 1'b0, 1'b0, 16'h3333);
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, 1'b0, 3'd4, 16'h0000);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_req_ready", j), 32'(bus.req_ready), 32'd0);
            check_rsp($sformatf("bp_hold%0d", j), 1'b1, 1'b0, 1'b0, 16'h3333);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check_rsp("bp_rd4", 1'b1, 1'b0, 1'b0, 16'h5555);
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("bp_drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Reset while a write response is held
        drive_req(1'b1, 1'b1, 3'd7, 16'hA5A5);
        @(negedge clk);
        check_rsp("wr7", 1'b1, 1'b1, 1'b0, 16'hA5A5);
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check_rsp("wr7_held", 1'b1, 1'b1, 1'b0, 16'hA5A5);
        #1;
        rst_n = 1'b0;
        #1;
        check_rsp("midrst", 1'b0, 1'b0, 1'b0, 16'h0000);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_word_valid", 32'(word_valid), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 3'd7, 16'h0000);
        @(negedge clk);
        check_rsp("rd7_after_rst", 1'b1, 1'b0, 1'b1, 16'h0000);
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);

        // Overwrite addr 0 twice, then read back
        drive_req(1'b1, 1'b1, 3'd0, 16'h0001);
        @(negedge clk);
        check_rsp("ow_wr1", 1'b1, 1'b1, 1'b0, 16'h0001);
        drive_req(1'b1, 1'b1, 3'd0, 16'hFFFF);
        @(negedge clk);
        check_rsp("ow_wr2", 1'b1, 1'b1, 1'b0, 16'hFFFF);
        drive_req(1'b1, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check_rsp("ow_rd", 1'b1, 1'b0, 1'b0, 16'hFFFF);
        check("ow_word_valid", 32'(word_valid), 32'h01);
        drive_req(1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        check("ow_drain_valid", 32'(bus.rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
